id_hazard_ctrl: RTL and testbench
=================================

Name: id_hazard_ctrl

Overview:
- ID-stage consumer of the IF/ID pipeline register. Decodes the latched instruction and its PC+4 value.
- Resolves branches and jumps in ID.
- Drives the back-channel into IF: hold the PC and IF/ID register, or flush IF/ID on a redirect.
- Keeps its own shadow of the ID/EX and EX/MEM destination registers to detect load-use and branch-operand hazards. Inserts bubbles toward EX.

Parameters:
- XLEN, 32, datapath and instruction width.
- NOP_INSTR, 32'h00000013, instruction treated as a bubble (addi x0,x0,0); all-zero is also a bubble.
- CNT_W, 16, width of the stall and flush performance counters (saturating).

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- instructionReg  input  XLEN  instruction from IF/ID.
- PCreg  input  XLEN  PC+4 of that instruction, from IF/ID.
- rs1_data  input  XLEN  register-file read of rs1, combinational, same cycle.
- rs2_data  input  XLEN  register-file read of rs2.
- pc_write  output  1  0 = IF holds its PC.
- ifid_write  output  1  0 = IF/ID holds its contents.
- ifid_flush  output  1  1 = IF/ID loads NOP_INSTR next edge.
- pc_src  output  1  1 = IF takes branch_target.
- branch_target  output  XLEN  redirect address.
- idex_bubble  output  1  1 = ID/EX loads a bubble.
- rs1, rs2, rd  output  5 each  decoded fields; rd forced to 0 if the instruction does not write.
- imm  output  XLEN  sign-extended immediate (I/S/B/U/J per opcode).
- stall_count  output  CNT_W  cycles with pc_write=0.
- flush_count  output  CNT_W  cycles with ifid_flush=1.

Behaviour:
- ISA subset: RV32I opcodes LOAD, STORE, OP, OP-IMM, LUI, AUIPC, BRANCH (BEQ/BNE/BLT/BGE/BLTU/BGEU), JAL, JALR. Unknown opcodes decode as a bubble.
- Bubble in ID (NOP_INSTR or 0):
  - rs1, rs2 and rd are 0.
  - No hazard is raised.
  - No redirect occurs.
- Shadow state, registered each posedge:
  - ex_rd and ex_is_load load the ID instruction's rd and is-load flag, or 0/0 when idex_bubble=1.
  - mem_rd and mem_is_load load the previous ex_rd and ex_is_load.
- Combinational hazard detect. A source counts only if the instruction uses it and it is nonzero.
  - load_use: ex_is_load and ex_rd matches a used source.
  - br_dep: the ID instruction is BRANCH or JALR, and either (a) ex_rd matches a used source, or (b) mem_is_load and mem_rd matches a used source.
  - stall = load_use or br_dep.
- When stall=1:
  - pc_write=0, ifid_write=0, idex_bubble=1, pc_src=0, ifid_flush=0.
  - Stall length falls out of the shadow pipeline: load-use = 1 cycle; branch on an ALU result = 1 cycle; branch on a load result = 2 cycles.
- Redirect, only when stall=0:
  - BRANCH: condition is evaluated on rs1_data/rs2_data; target = (PCreg-4)+imm.
  - JAL: always taken; target = (PCreg-4)+imm.
  - JALR: always taken; target = (rs1_data+imm) with bit 0 cleared.
  - When taken: pc_src=1 and ifid_flush=1 in the same cycle. pc_write=1, ifid_write=1, idex_bubble=0 (the branch itself proceeds).
  - Not taken: pc_src=0, ifid_flush=0.
- Priority: reset > stall > redirect > normal flow.
- Arithmetic is mod 2^XLEN; target wrap-around is not trapped.
- Counters:
  - stall_count increments on each stall cycle.
  - flush_count increments on each redirect cycle.
  - Both saturate at all-ones and never wrap.
- Reset, including mid-stall:
  - Next cycle: shadow regs 0, counters 0.
  - Outputs then follow the combinational rules with empty shadows, so no stall is raised.
  - A 2-cycle stall in progress is abandoned.

Decomposition:
- Shared package (riscv_pkg) holds:
  - opcode constants (OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_BRANCH, OPC_JAL, OPC_JALR);
  - funct3 branch codes;
  - NOP_INSTR;
  - an imm_type enum.
- Sub-module imm_gen: combinational instruction-to-immediate. It is natural to split out and is reused by EX.

Test Plan:
- Reset with instructionReg=0 -> all counters 0; pc_write=1, ifid_write=1, idex_bubble=0, pc_src=0.
- lw x5,0(x1), then add x6,x5,x2 in ID next cycle -> exactly 1 cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_count=1.
- lw x5 then beq x5,x0 -> 2 stall cycles. Then with rs1_data=0, PCreg=0x104, imm=0x20: pc_src=1, ifid_flush=1, branch_target=0x120; flush_count=1.
- add x7,... then bne x7,x7 -> 1 stall cycle, then not taken: pc_src=0, ifid_flush=0.
- jalr x1,4(x3) with rs1_data=0x1001 -> branch_target=0x1004, pc_src=1. Also add x0,... followed by a consumer of x0 -> no stall.
- Assert reset during the 2nd cycle of a load-branch stall -> next cycle shadows cleared, stall=0, counters 0.
- Drive 2^CNT_W+3 stall cycles -> stall_count holds all-ones.

Source files
------------

// File: rtl/riscv_pkg.sv
// RV32I decode constants and opcode classification shared by the ID and EX stages.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    typedef struct packed {
        logic valid;
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
        logic is_load;
        logic is_branch;
        logic is_jal;
        logic is_jalr;
    } op_class_t;

    function automatic imm_type_e imm_type_of(input logic [6:0] opc);
        imm_type_e t;
        t = IMM_NONE;
        case (opc)
            OPC_LOAD, OPC_OPIMM, OPC_JALR: t = IMM_I;
            OPC_STORE:                     t = IMM_S;
            OPC_BRANCH:                    t = IMM_B;
            OPC_LUI, OPC_AUIPC:            t = IMM_U;
            OPC_JAL:                       t = IMM_J;
            default:                       t = IMM_NONE;
        endcase
        return t;
    endfunction

    function automatic op_class_t classify(input logic [6:0] opc);
        op_class_t c;
        c = '0;
        case (opc)
            OPC_LOAD: begin
                c.valid     = 1'b1;
                c.uses_rs1  = 1'b1;
                c.writes_rd = 1'b1;
                c.is_load   = 1'b1;
            end
            OPC_STORE: begin
                c.valid    = 1'b1;
                c.uses_rs1 = 1'b1;
                c.uses_rs2 = 1'b1;
            end
            OPC_OP: begin
                c.valid     = 1'b1;
                c.uses_rs1  = 1'b1;
                c.uses_rs2  = 1'b1;
                c.writes_rd = 1'b1;
            end
            OPC_OPIMM: begin
                c.valid     = 1'b1;
                c.uses_rs1  = 1'b1;
                c.writes_rd = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                c.valid     = 1'b1;
                c.writes_rd = 1'b1;
            end
            OPC_BRANCH: begin
                c.valid     = 1'b1;
                c.uses_rs1  = 1'b1;
                c.uses_rs2  = 1'b1;
                c.is_branch = 1'b1;
            end
            OPC_JAL: begin
                c.valid     = 1'b1;
                c.writes_rd = 1'b1;
                c.is_jal    = 1'b1;
            end
            OPC_JALR: begin
                c.valid     = 1'b1;
                c.uses_rs1  = 1'b1;
                c.writes_rd = 1'b1;
                c.is_jalr   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction; format chosen from the opcode.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] imm
);

    imm_type_e kind;

    always_comb begin
        kind = imm_type_of(instr[6:0]);
        imm  = '0;
        case (kind)
            IMM_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            IMM_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = XLEN'($signed({instr[31:12], 12'h000}));
            IMM_J: imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID stage: decode, branch/jump resolution, load-use and branch-operand hazard
// control toward IF and EX, with saturating stall/flush counters.
module id_hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(riscv_pkg::NOP_INSTR),
    parameter int unsigned     CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  instructionReg,
    input  logic [XLEN-1:0]  PCreg,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             pc_src,
    output logic [XLEN-1:0]  branch_target,
    output logic             idex_bubble,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [XLEN-1:0]  imm,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    op_class_t  cls;
    logic [2:0] funct3;
    logic       bubble;
    logic       use1;
    logic       use2;

    logic [4:0] ex_rd;
    logic [4:0] mem_rd;
    logic       ex_is_load;
    logic       mem_is_load;

    logic       hit_ex;
    logic       hit_mem;
    logic       load_use;
    logic       br_dep;
    logic       stall;
    logic       br_cond;
    logic       taken;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (instructionReg),
        .imm   (imm)
    );

    // A bubble (NOP, all-zero or unknown opcode) decodes to an empty class,
    // which suppresses register fields, hazards and redirects in one place.
    always_comb begin
        funct3 = instructionReg[14:12];
        cls    = classify(instructionReg[6:0]);
        bubble = (instructionReg == NOP_INSTR) || (instructionReg == '0) || !cls.valid;
        if (bubble) begin
            cls = '0;
        end
        rs1  = cls.valid     ? instructionReg[19:15] : '0;
        rs2  = cls.valid     ? instructionReg[24:20] : '0;
        rd   = cls.writes_rd ? instructionReg[11:7]  : '0;
        use1 = cls.uses_rs1 && (rs1 != '0);
        use2 = cls.uses_rs2 && (rs2 != '0);
    end

    always_comb begin
        hit_ex   = (use1 && (ex_rd == rs1))  || (use2 && (ex_rd == rs2));
        hit_mem  = (use1 && (mem_rd == rs1)) || (use2 && (mem_rd == rs2));
        load_use = ex_is_load && hit_ex;
        br_dep   = (cls.is_branch || cls.is_jalr) && (hit_ex || (mem_is_load && hit_mem));
        stall    = load_use || br_dep;
    end

    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            F3_BEQ:  br_cond = (rs1_data == rs2_data);
            F3_BNE:  br_cond = (rs1_data != rs2_data);
            F3_BLT:  br_cond = ($signed(rs1_data) <  $signed(rs2_data));
            F3_BGE:  br_cond = ($signed(rs1_data) >= $signed(rs2_data));
            F3_BLTU: br_cond = (rs1_data <  rs2_data);
            F3_BGEU: br_cond = (rs1_data >= rs2_data);
            default: br_cond = 1'b0;
        endcase
        taken = cls.is_jal || cls.is_jalr || (cls.is_branch && br_cond);

        if (cls.is_jalr) begin
            branch_target = (rs1_data + imm) & ~XLEN'(1);
        end else begin
            branch_target = (PCreg - XLEN'(4)) + imm;
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        pc_src      = 1'b0;
        ifid_flush  = 1'b0;
        if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (taken) begin
            pc_src     = 1'b1;
            ifid_flush = 1'b1;
        end
    end

    // Shadow of the EX and MEM destinations; a stall pushes an empty slot,
    // so stall length follows from how far the producer has advanced.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rd       <= '0;
            ex_is_load  <= 1'b0;
            mem_rd      <= '0;
            mem_is_load <= 1'b0;
        end else begin
            ex_rd       <= idex_bubble ? 5'd0 : rd;
            ex_is_load  <= !idex_bubble && cls.is_load;
            mem_rd      <= ex_rd;
            mem_is_load <= ex_is_load;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!pc_write && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (ifid_flush && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus random instruction streams
// compared against a history-based reference model of the ID stage.
module tb_id_hazard_ctrl;

    localparam int unsigned CW  = 8;
    localparam int unsigned SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   instructionReg, PCreg, rs1_data, rs2_data;
    logic          pc_write, ifid_write, ifid_flush, pc_src, idex_bubble;
    logic [31:0]   branch_target, imm;
    logic [4:0]    rs1, rs2, rd;
    logic [CW-1:0] stall_count, flush_count;

    always #5 clk = ~clk;

    id_hazard_ctrl #(.XLEN(32), .NOP_INSTR(32'h0000_0013), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .instructionReg(instructionReg), .PCreg(PCreg),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .pc_write(pc_write),
        .ifid_write(ifid_write), .ifid_flush(ifid_flush), .pc_src(pc_src),
        .branch_target(branch_target), .idex_bubble(idex_bubble), .rs1(rs1),
        .rs2(rs2), .rd(rd), .imm(imm), .stall_count(stall_count),
        .flush_count(flush_count)
    );

    int tests = 0;
    int fails = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        bit          bub;
        int unsigned rs1, rs2, rd;
        bit          u1, u2, ld, br, jal, jalr;
        logic [31:0] imm;
    } ref_dec_t;

    typedef struct {
        int unsigned rd;
        bit          ld;
    } slot_t;

    // Instructions that entered EX, newest at the back.
    slot_t       hist[$];
    int unsigned m_stall, m_flush;
    bit          p_rst, p_stall, p_flush;
    slot_t       p_slot;

    function automatic logic [31:0] sx(input logic [31:0] v, input int unsigned n);
        return v[n-1] ? v - (32'd1 << n) : v;
    endfunction

    function automatic ref_dec_t ref_decode(input logic [31:0] i);
        ref_dec_t d;
        bit wr;
        d.bub = 0; d.u1 = 0; d.u2 = 0; d.ld = 0; d.br = 0; d.jal = 0; d.jalr = 0;
        d.rs1 = 0; d.rs2 = 0; d.rd = 0; d.imm = 0; wr = 0;
        case (i[6:0])
            7'h03: begin d.u1 = 1; wr = 1; d.ld = 1; d.imm = sx(i[31:20], 12); end
            7'h23: begin d.u1 = 1; d.u2 = 1; d.imm = sx({i[31:25], i[11:7]}, 12); end
            7'h33: begin d.u1 = 1; d.u2 = 1; wr = 1; end
            7'h13: begin d.u1 = 1; wr = 1; d.imm = sx(i[31:20], 12); end
            7'h37, 7'h17: begin wr = 1; d.imm = {i[31:12], 12'h000}; end
            7'h63: begin
                d.u1 = 1; d.u2 = 1; d.br = 1;
                d.imm = sx({i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
            end
            7'h6f: begin wr = 1; d.jal = 1; d.imm = sx({i[31], i[19:12], i[20], i[30:21], 1'b0}, 21); end
            7'h67: begin d.u1 = 1; wr = 1; d.jalr = 1; d.imm = sx(i[31:20], 12); end
            default: d.bub = 1;
        endcase
        if (i == 32'h0 || i == 32'h13) d.bub = 1;
        if (d.bub) begin
            d.u1 = 0; d.u2 = 0; d.ld = 0; d.br = 0; d.jal = 0; d.jalr = 0; d.imm = 0;
            return d;
        end
        d.rs1 = i[19:15];
        d.rs2 = i[24:20];
        d.rd  = wr ? i[11:7] : 0;
        d.u1  = d.u1 && d.rs1 != 0;
        d.u2  = d.u2 && d.rs2 != 0;
        return d;
    endfunction

    task automatic apply(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b, input bit rst);
        ref_dec_t    d;
        slot_t       ex, mem;
        bit          hit_ex, hit_mem, stall, cond, taken;
        logic [31:0] tgt;
        logic [2:0]  f3;
        reset = rst; instructionReg = ins; PCreg = pc; rs1_data = a; rs2_data = b;
        #2;
        d   = ref_decode(ins);
        ex  = hist[hist.size()-1];
        mem = hist[hist.size()-2];
        hit_ex  = (d.u1 && ex.rd == d.rs1)  || (d.u2 && ex.rd == d.rs2);
        hit_mem = (d.u1 && mem.rd == d.rs1) || (d.u2 && mem.rd == d.rs2);
        stall = (ex.ld && hit_ex) || ((d.br || d.jalr) && (hit_ex || (mem.ld && hit_mem)));
        f3 = ins[14:12];
        case (f3)
            3'd0: cond = (a == b);
            3'd1: cond = (a != b);
            3'd4: cond = ($signed(a) <  $signed(b));
            3'd5: cond = ($signed(a) >= $signed(b));
            3'd6: cond = (a <  b);
            3'd7: cond = (a >= b);
            default: cond = 0;
        endcase
        taken = !stall && (d.jal || d.jalr || (d.br && cond));
        tgt   = d.jalr ? ((a + d.imm) & ~32'd1) : (pc - 32'd4 + d.imm);

        check_eq("pc_write",    pc_write,    !stall);
        check_eq("ifid_write",  ifid_write,  !stall);
        check_eq("idex_bubble", idex_bubble, stall);
        check_eq("pc_src",      pc_src,      taken);
        check_eq("ifid_flush",  ifid_flush,  taken);
        check_eq("rs1",         rs1,         d.rs1);
        check_eq("rs2",         rs2,         d.rs2);
        check_eq("rd",          rd,          d.rd);
        check_eq("imm",         imm,         d.imm);
        check_eq("stall_count", stall_count, m_stall);
        check_eq("flush_count", flush_count, m_flush);
        if (taken) check_eq("branch_target", branch_target, tgt);

        p_rst   = rst;
        p_stall = stall;
        p_flush = taken;
        p_slot  = stall ? slot_t'{0, 0} : slot_t'{d.rd, d.ld};
    endtask

    task automatic model_clear();
        hist.delete();
        hist.push_back(slot_t'{0, 0});
        hist.push_back(slot_t'{0, 0});
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (p_rst) begin
            model_clear();
        end else begin
            hist.push_back(p_slot);
            if (hist.size() > 4) void'(hist.pop_front());
            if (p_stall && m_stall < SAT) m_stall++;
            if (p_flush && m_flush < SAT) m_flush++;
        end
        #1;
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] s1,
                                          input logic [2:0] f3, input logic [4:0] d,
                                          input logic [6:0] op);
        return {im, s1, f3, d, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] s2, input logic [4:0] s1,
                                          input logic [4:0] d);
        return {7'd0, s2, s1, 3'b000, d, 7'h33};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] s2,
                                          input logic [4:0] s1, input logic [2:0] f3);
        return {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops[9] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h37, 7'h17, 7'h63, 7'h6f, 7'h67};
        logic [2:0]  bf3[6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        int unsigned k;
        logic [31:0] r;
        k = $urandom_range(0, 11);
        r = $urandom;
        if (k == 9)  return 32'h0;
        if (k == 10) return 32'h13;
        r[6:0]   = (k == 11) ? 7'h0B : ops[k];
        r[11:7]  = 5'($urandom_range(0, 3));
        r[19:15] = 5'($urandom_range(0, 3));
        r[24:20] = 5'($urandom_range(0, 3));
        if (k == 6) r[14:12] = bf3[$urandom_range(0, 5)];
        return r;
    endfunction

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 3))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] lw5, add6, beq5, add7, bne77, jalr1, add0, beq00, jal1, a, b;
        lw5   = enc_i(12'd0, 5'd1, 3'b010, 5'd5, 7'h03);
        add6  = enc_r(5'd2, 5'd5, 5'd6);
        beq5  = enc_b(13'h20, 5'd0, 5'd5, 3'b000);
        add7  = enc_r(5'd2, 5'd1, 5'd7);
        bne77 = enc_b(13'h40, 5'd7, 5'd7, 3'b001);
        jalr1 = enc_i(12'd4, 5'd3, 3'b000, 5'd1, 7'h67);
        add0  = enc_r(5'd2, 5'd1, 5'd0);
        beq00 = enc_b(13'h8, 5'd0, 5'd0, 3'b000);
        jal1  = 32'h0000_00EF;

        reset = 1'b1; instructionReg = '0; PCreg = '0; rs1_data = '0; rs2_data = '0;
        @(posedge clk); @(posedge clk); #1;
        model_clear();

        apply(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        check_eq("rst_pcw", pc_write, 1);
        check_eq("rst_ifidw", ifid_write, 1);
        check_eq("rst_bub", idex_bubble, 0);
        check_eq("rst_src", pc_src, 0);
        tick();

        apply(lw5, 32'h100, 32'h0, 32'h0, 1'b0); tick();
        apply(add6, 32'h104, 32'h0, 32'h0, 1'b0);
        check_eq("lu_pcw", pc_write, 0);
        check_eq("lu_bub", idex_bubble, 1);
        tick();
        check_eq("lu_cnt", stall_count, 1);
        apply(add6, 32'h104, 32'h0, 32'h0, 1'b0);
        check_eq("lu_release", pc_write, 1);
        tick();

        apply(lw5, 32'h100, 32'h0, 32'h0, 1'b0); tick();
        repeat (2) begin
            apply(beq5, 32'h104, 32'h0, 32'h0, 1'b0);
            check_eq("ldbr_stall", pc_write, 0);
            tick();
        end
        apply(beq5, 32'h104, 32'h0, 32'h0, 1'b0);
        check_eq("ldbr_src", pc_src, 1);
        check_eq("ldbr_flush", ifid_flush, 1);
        check_eq("ldbr_tgt", branch_target, 32'h120);
        tick();
        check_eq("ldbr_fcnt", flush_count, 1);

        apply(add7, 32'h200, 32'h0, 32'h0, 1'b0); tick();
        apply(bne77, 32'h204, 32'h5, 32'h5, 1'b0);
        check_eq("alubr_stall", pc_write, 0);
        tick();
        apply(bne77, 32'h204, 32'h5, 32'h5, 1'b0);
        check_eq("alubr_src", pc_src, 0);
        check_eq("alubr_flush", ifid_flush, 0);
        tick();

        apply(jalr1, 32'h300, 32'h1001, 32'h0, 1'b0);
        check_eq("jalr_tgt", branch_target, 32'h1004);
        check_eq("jalr_src", pc_src, 1);
        tick();
        apply(add0, 32'h400, 32'h0, 32'h0, 1'b0); tick();
        apply(beq00, 32'h404, 32'h0, 32'h0, 1'b0);
        check_eq("x0_nostall", pc_write, 1);
        tick();

        apply(lw5, 32'h100, 32'h0, 32'h0, 1'b0); tick();
        apply(beq5, 32'h104, 32'h1, 32'h0, 1'b0); tick();
        apply(beq5, 32'h104, 32'h1, 32'h0, 1'b1); tick();
        apply(beq5, 32'h104, 32'h1, 32'h0, 1'b0);
        check_eq("rstmid_pcw", pc_write, 1);
        check_eq("rstmid_scnt", stall_count, 0);
        check_eq("rstmid_fcnt", flush_count, 0);
        tick();

        for (int n = 0; n < 140; n++) begin
            apply(lw5, 32'h100, 32'h0, 32'h0, 1'b0); tick();
            repeat (3) begin
                apply(beq5, 32'h104, 32'h0, 32'h0, 1'b0); tick();
            end
        end
        check_eq("stall_sat", stall_count, SAT);
        for (int n = 0; n < 300; n++) begin
            apply(jal1, 32'h500, 32'h0, 32'h0, 1'b0); tick();
        end
        check_eq("flush_sat", flush_count, SAT);

        for (int n = 0; n < 2000; n++) begin
            a = rand_data();
            b = ($urandom_range(0, 1) == 1) ? a : rand_data();
            apply(rand_instr(), $urandom, a, b, $urandom_range(0, 63) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
